// File: rtl/mdu_sched_pkg.sv
// Shared definitions for the divide scheduler: state encodings, register-file
// bus widths and the wait counter helper.
package mdu_sched_pkg;

    localparam int unsigned RegAddrBus = 5;
    localparam int unsigned RegBus     = 32;
    localparam int unsigned WaitCntW   = 4;

    localparam logic [RegAddrBus-1:0] ZeroReg      = '0;
    localparam logic                  WriteEnable  = 1'b1;
    localparam logic                  WriteDisable = 1'b0;

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StHold
    } state_e;

    function automatic logic [WaitCntW-1:0] sat_inc(input logic [WaitCntW-1:0] v);
        return (v == {WaitCntW{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/mdu_hazard.sv
// Combinational hazard detector: compares decode operands against the
// destination of the outstanding divide.
module mdu_hazard
    import mdu_sched_pkg::*;
(
    input  logic                  active,
    input  logic [RegAddrBus-1:0] pend_rd,
    input  logic [RegAddrBus-1:0] reg1_raddr,
    input  logic [RegAddrBus-1:0] reg2_raddr,
    input  logic                  reg_we,
    input  logic [RegAddrBus-1:0] reg_waddr,
    input  logic                  is_div,
    output logic                  hazard
);

    logic rd_valid;
    logic raw1;
    logic raw2;
    logic waw;

    always_comb begin
        rd_valid = (pend_rd != ZeroReg);
        raw1     = rd_valid && (reg1_raddr == pend_rd);
        raw2     = rd_valid && (reg2_raddr == pend_rd);
        waw      = rd_valid && reg_we && (reg_waddr == pend_rd);
        // A second divide must wait: only one may be outstanding.
        hazard   = active && (raw1 || raw2 || waw || is_div);
    end

endmodule

// File: rtl/mdu_sched.sv
// Tracks the single outstanding divide, stalls decode on hazards with it and
// arbitrates the register-file write port between execute and the divide result.
module mdu_sched
    import mdu_sched_pkg::*;
#(
    parameter int unsigned WAIT_MAX = 4,
    parameter int unsigned DW       = RegBus
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  div_start_i,
    input  logic [RegAddrBus-1:0] div_rd_i,
    input  logic                  div_done_i,
    input  logic [DW-1:0]         div_result_i,
    input  logic [RegAddrBus-1:0] id_reg1_raddr_i,
    input  logic [RegAddrBus-1:0] id_reg2_raddr_i,
    input  logic                  id_reg_we_i,
    input  logic [RegAddrBus-1:0] id_reg_waddr_i,
    input  logic                  id_is_div_i,
    input  logic                  ex_reg_we_i,
    input  logic [RegAddrBus-1:0] ex_reg_waddr_i,
    input  logic [DW-1:0]         ex_reg_wdata_i,
    output logic                  reg_we_o,
    output logic [RegAddrBus-1:0] reg_waddr_o,
    output logic [DW-1:0]         reg_wdata_o,
    output logic                  stall_o,
    output logic                  ex_hold_o,
    output logic                  div_busy_o,
    output logic                  err_o
);

    localparam logic [WaitCntW-1:0] WaitLimit = WaitCntW'(WAIT_MAX);

    state_e                state_q;
    state_e                state_d;
    logic [RegAddrBus-1:0] pend_rd_q;
    logic [DW-1:0]         pend_data_q;
    logic [WaitCntW-1:0]   wait_cnt_q;
    logic                  err_q;

    logic active;
    logic hazard;
    logic div_win;
    logic rd_zero;

    always_comb begin
        active  = (state_q != StIdle);
        rd_zero = (pend_rd_q == ZeroReg);
        // The buffered result takes the port when execute is idle or it has waited long enough.
        div_win = (state_q == StHold) && !rd_zero &&
                  (!ex_reg_we_i || (wait_cnt_q == WaitLimit));
    end

    mdu_hazard u_hazard (
        .active     (active),
        .pend_rd    (pend_rd_q),
        .reg1_raddr (id_reg1_raddr_i),
        .reg2_raddr (id_reg2_raddr_i),
        .reg_we     (id_reg_we_i),
        .reg_waddr  (id_reg_waddr_i),
        .is_div     (id_is_div_i),
        .hazard     (hazard)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (div_start_i) state_d = StBusy;
            StBusy: if (div_done_i) state_d = StHold;
            StHold: if (rd_zero || div_win) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_rd_q   <= ZeroReg;
            pend_data_q <= '0;
            wait_cnt_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            if (state_q == StIdle && div_start_i) begin
                pend_rd_q <= div_rd_i;
            end
            if (state_q != StIdle && div_start_i) begin
                err_q <= 1'b1;
            end
            if (state_q == StBusy && div_done_i) begin
                pend_data_q <= div_result_i;
                wait_cnt_q  <= '0;
            end else if (state_q == StHold && !rd_zero && !div_win) begin
                wait_cnt_q <= sat_inc(wait_cnt_q);
            end
        end
    end

    always_comb begin
        reg_we_o    = WriteDisable;
        reg_waddr_o = ZeroReg;
        reg_wdata_o = '0;
        stall_o     = 1'b0;
        ex_hold_o   = 1'b0;
        div_busy_o  = 1'b0;
        err_o       = 1'b0;
        if (!rst) begin
            if (div_win) begin
                reg_we_o    = WriteEnable;
                reg_waddr_o = pend_rd_q;
                reg_wdata_o = pend_data_q;
                ex_hold_o   = ex_reg_we_i;
            end else begin
                reg_we_o    = ex_reg_we_i;
                reg_waddr_o = ex_reg_waddr_i;
                reg_wdata_o = ex_reg_wdata_i;
            end
            stall_o    = hazard || (div_win && ex_reg_we_i);
            div_busy_o = active;
            err_o      = err_q;
        end
    end

endmodule

// File: tb/tb_mdu_sched.sv
// Directed self-checking bench for mdu_sched with WAIT_MAX=4.
module tb_mdu_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        div_start_i;
    logic [4:0]  div_rd_i;
    logic        div_done_i;
    logic [31:0] div_result_i;
    logic [4:0]  id_reg1_raddr_i;
    logic [4:0]  id_reg2_raddr_i;
    logic        id_reg_we_i;
    logic [4:0]  id_reg_waddr_i;
    logic        id_is_div_i;
    logic        ex_reg_we_i;
    logic [4:0]  ex_reg_waddr_i;
    logic [31:0] ex_reg_wdata_i;
    logic        reg_we_o;
    logic [4:0]  reg_waddr_o;
    logic [31:0] reg_wdata_o;
    logic        stall_o;
    logic        ex_hold_o;
    logic        div_busy_o;
    logic        err_o;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    mdu_sched #(
        .WAIT_MAX (4),
        .DW       (32)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .div_start_i     (div_start_i),
        .div_rd_i        (div_rd_i),
        .div_done_i      (div_done_i),
        .div_result_i    (div_result_i),
        .id_reg1_raddr_i (id_reg1_raddr_i),
        .id_reg2_raddr_i (id_reg2_raddr_i),
        .id_reg_we_i     (id_reg_we_i),
        .id_reg_waddr_i  (id_reg_waddr_i),
        .id_is_div_i     (id_is_div_i),
        .ex_reg_we_i     (ex_reg_we_i),
        .ex_reg_waddr_i  (ex_reg_waddr_i),
        .ex_reg_wdata_i  (ex_reg_wdata_i),
        .reg_we_o        (reg_we_o),
        .reg_waddr_o     (reg_waddr_o),
        .reg_wdata_o     (reg_wdata_o),
        .stall_o         (stall_o),
        .ex_hold_o       (ex_hold_o),
        .div_busy_o      (div_busy_o),
        .err_o           (err_o)
    );

    // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic clear_inputs();
        div_start_i = 0; div_rd_i = 0; div_done_i = 0; div_result_i = 0;
        id_reg1_raddr_i = 0; id_reg2_raddr_i = 0; id_reg_we_i = 0; id_reg_waddr_i = 0;
        id_is_div_i = 0; ex_reg_we_i = 0; ex_reg_waddr_i = 0; ex_reg_wdata_i = 0;
    endtask

    task automatic test_reset();
        rst = 1;
        clear_inputs();
        ex_reg_we_i = 1; ex_reg_waddr_i = 5'd3; ex_reg_wdata_i = 32'h1234;
        id_is_div_i = 1;
        next_cycle();
        next_cycle();
        settle();
        checks++;
        if ({reg_we_o, reg_waddr_o, reg_wdata_o, stall_o, ex_hold_o, div_busy_o, err_o} !== '0)
            $display("FAIL reset_outputs: got we=%b wa=%0d wd=%h st=%b hold=%b busy=%b err=%b, want all 0",
                     reg_we_o, reg_waddr_o, reg_wdata_o, stall_o, ex_hold_o, div_busy_o, err_o);
        else passed++;
        rst = 0;
        clear_inputs();
        next_cycle();
        settle();
        checks++;
        if ({div_busy_o, stall_o, err_o, reg_we_o} !== 4'b0000)
            $display("FAIL reset_idle: got busy=%b st=%b err=%b we=%b, want 0000",
                     div_busy_o, stall_o, err_o, reg_we_o);
        else passed++;
    endtask

    task automatic test_basic();
        div_start_i = 1; div_rd_i = 5'd5;
        next_cycle();
        div_start_i = 0;
        id_reg1_raddr_i = 5'd5;
        settle();
        checks++;
        if ({div_busy_o, stall_o} !== 2'b11)
            $display("FAIL basic_raw1: got busy=%b stall=%b, want 1 1", div_busy_o, stall_o);
        else passed++;
        id_reg1_raddr_i = 5'd6;
        settle();
        checks++;
        if (stall_o !== 1'b0) $display("FAIL basic_noraw_x6: got stall=%b, want 0", stall_o);
        else passed++;
        id_reg1_raddr_i = 0; id_reg2_raddr_i = 5'd5;
        settle();
        checks++;
        if (stall_o !== 1'b1) $display("FAIL basic_raw2: got stall=%b, want 1", stall_o);
        else passed++;
        id_reg2_raddr_i = 0; id_reg_we_i = 1; id_reg_waddr_i = 5'd5;
        settle();
        checks++;
        if (stall_o !== 1'b1) $display("FAIL basic_waw: got stall=%b, want 1", stall_o);
        else passed++;
        id_reg_we_i = 0; id_reg_waddr_i = 0;
        ex_reg_we_i = 1; ex_reg_waddr_i = 5'd2; ex_reg_wdata_i = 32'h55;
        settle();
        checks++;
        if ({reg_we_o, reg_waddr_o, reg_wdata_o} !== {1'b1, 5'd2, 32'h55})
            $display("FAIL basic_passthru: got we=%b wa=%0d wd=%h, want 1 2 00000055",
                     reg_we_o, reg_waddr_o, reg_wdata_o);
        else passed++;
        ex_reg_we_i = 0; ex_reg_waddr_i = 0; ex_reg_wdata_i = 0;
        for (int i = 0; i < 9; i++) next_cycle();
        div_done_i = 1; div_result_i = 32'h0000_0007;
        id_reg1_raddr_i = 5'd5;
        settle();
        checks++;
        if ({reg_we_o, stall_o} !== 2'b01)
            $display("FAIL basic_done_cycle: got we=%b stall=%b, want 0 1", reg_we_o, stall_o);
        else passed++;
        next_cycle();
        div_done_i = 0; div_result_i = 0;
        settle();
        checks++;
        if ({reg_we_o, reg_waddr_o, reg_wdata_o, ex_hold_o, stall_o} !==
            {1'b1, 5'd5, 32'h7, 1'b0, 1'b1})
            $display("FAIL basic_write: got we=%b wa=%0d wd=%h hold=%b st=%b, want 1 5 7 0 1",
                     reg_we_o, reg_waddr_o, reg_wdata_o, ex_hold_o, stall_o);
        else passed++;
        next_cycle();
        settle();
        checks++;
        if ({div_busy_o, stall_o, reg_we_o} !== 3'b000)
            $display("FAIL basic_after_write: got busy=%b st=%b we=%b, want 000",
                     div_busy_o, stall_o, reg_we_o);
        else passed++;
        clear_inputs();
    endtask

    task automatic test_contention();
        div_start_i = 1; div_rd_i = 5'd9;
        next_cycle();
        div_start_i = 0;
        div_done_i = 1; div_result_i = 32'hABCD;
        ex_reg_we_i = 1; ex_reg_waddr_i = 5'd3; ex_reg_wdata_i = 32'h100;
        next_cycle();
        div_done_i = 0; div_result_i = 0;
        for (int k = 1; k <= 4; k++) begin
            ex_reg_wdata_i = 32'h100 + k;
            settle();
            checks++;
            if ({reg_we_o, reg_waddr_o, reg_wdata_o, ex_hold_o} !== {1'b1, 5'd3, 32'h100 + k, 1'b0})
                $display("FAIL contention_ex_%0d: got we=%b wa=%0d wd=%h hold=%b, want 1 3 %h 0",
                         k, reg_we_o, reg_waddr_o, reg_wdata_o, ex_hold_o, 32'h100 + k);
            else passed++;
            next_cycle();
        end
        ex_reg_wdata_i = 32'h105;
        settle();
        checks++;
        if ({reg_we_o, reg_waddr_o, reg_wdata_o, ex_hold_o, stall_o} !==
            {1'b1, 5'd9, 32'hABCD, 1'b1, 1'b1})
            $display("FAIL contention_forced: got we=%b wa=%0d wd=%h hold=%b st=%b, want 1 9 abcd 1 1",
                     reg_we_o, reg_waddr_o, reg_wdata_o, ex_hold_o, stall_o);
        else passed++;
        next_cycle();
        settle();
        checks++;
        if ({reg_waddr_o, reg_wdata_o, ex_hold_o, div_busy_o, stall_o} !==
            {5'd3, 32'h105, 1'b0, 1'b0, 1'b0})
            $display("FAIL contention_replay: got wa=%0d wd=%h hold=%b busy=%b st=%b, want 3 105 0 0 0",
                     reg_waddr_o, reg_wdata_o, ex_hold_o, div_busy_o, stall_o);
        else passed++;
        clear_inputs();
    endtask

    task automatic test_rd_zero();
        div_start_i = 1; div_rd_i = 5'd0;
        next_cycle();
        div_start_i = 0;
        id_reg1_raddr_i = 0; id_reg2_raddr_i = 0; id_reg_we_i = 1; id_reg_waddr_i = 0;
        settle();
        checks++;
        if ({div_busy_o, stall_o} !== 2'b10)
            $display("FAIL rd0_nohazard: got busy=%b stall=%b, want 1 0", div_busy_o, stall_o);
        else passed++;
        div_done_i = 1; div_result_i = 32'hDEAD;
        next_cycle();
        div_done_i = 0;
        settle();
        checks++;
        if ({reg_we_o, div_busy_o} !== 2'b01)
            $display("FAIL rd0_nowrite: got we=%b busy=%b, want 0 1", reg_we_o, div_busy_o);
        else passed++;
        next_cycle();
        settle();
        checks++;
        if ({reg_we_o, div_busy_o} !== 2'b00)
            $display("FAIL rd0_idle: got we=%b busy=%b, want 0 0", reg_we_o, div_busy_o);
        else passed++;
        clear_inputs();
    endtask

    task automatic test_back_to_back();
        div_start_i = 1; div_rd_i = 5'd7;
        next_cycle();
        div_start_i = 0;
        id_is_div_i = 1;
        settle();
        checks++;
        if ({stall_o, err_o} !== 2'b10)
            $display("FAIL b2b_div_stall: got stall=%b err=%b, want 1 0", stall_o, err_o);
        else passed++;
        div_start_i = 1; div_rd_i = 5'd8;
        next_cycle();
        div_start_i = 0; id_is_div_i = 0;
        id_reg1_raddr_i = 5'd8;
        settle();
        checks++;
        if ({err_o, stall_o} !== 2'b10)
            $display("FAIL b2b_err_ignored: got err=%b stall(x8)=%b, want 1 0", err_o, stall_o);
        else passed++;
        id_reg1_raddr_i = 5'd7;
        settle();
        checks++;
        if (stall_o !== 1'b1) $display("FAIL b2b_rd_kept: got stall(x7)=%b, want 1", stall_o);
        else passed++;
        div_done_i = 1; div_result_i = 32'h77;
        next_cycle();
        div_done_i = 0;
        settle();
        checks++;
        if ({reg_we_o, reg_waddr_o, reg_wdata_o} !== {1'b1, 5'd7, 32'h77})
            $display("FAIL b2b_write: got we=%b wa=%0d wd=%h, want 1 7 77",
                     reg_we_o, reg_waddr_o, reg_wdata_o);
        else passed++;
        next_cycle();
        next_cycle();
        settle();
        checks++;
        if ({err_o, div_busy_o} !== 2'b10)
            $display("FAIL b2b_err_sticky: got err=%b busy=%b, want 1 0", err_o, div_busy_o);
        else passed++;
        clear_inputs();
    endtask

    task automatic test_reset_mid();
        div_start_i = 1; div_rd_i = 5'd4;
        next_cycle();
        div_start_i = 0;
        rst = 1;
        ex_reg_we_i = 1; ex_reg_waddr_i = 5'd1; ex_reg_wdata_i = 32'hFF;
        id_reg1_raddr_i = 5'd4;
        settle();
        checks++;
        if ({reg_we_o, reg_waddr_o, reg_wdata_o, stall_o, ex_hold_o, div_busy_o, err_o} !== '0)
            $display("FAIL rstmid_outputs: got we=%b wa=%0d wd=%h st=%b hold=%b busy=%b err=%b, want all 0",
                     reg_we_o, reg_waddr_o, reg_wdata_o, stall_o, ex_hold_o, div_busy_o, err_o);
        else passed++;
        next_cycle();
        rst = 0;
        ex_reg_we_i = 0;
        div_done_i = 1; div_result_i = 32'h5;
        settle();
        checks++;
        if ({reg_we_o, div_busy_o, stall_o, err_o} !== 4'b0000)
            $display("FAIL rstmid_done_ignored: got we=%b busy=%b st=%b err=%b, want 0000",
                     reg_we_o, div_busy_o, stall_o, err_o);
        else passed++;
        next_cycle();
        div_done_i = 0;
        settle();
        checks++;
        if ({reg_we_o, div_busy_o, err_o} !== 3'b000)
            $display("FAIL rstmid_idle: got we=%b busy=%b err=%b, want 000",
                     reg_we_o, div_busy_o, err_o);
        else passed++;
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_contention();
        test_rd_zero();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
